dmem_responder: RTL

- Data-memory responder for the CPE CPU.
- Consumes the mem_rd/mem_wr strobes from the instruction decoder plus the execute-stage address, store data and funct3.
- Services each access against an internal word-organised RAM with a configurable wait-state latency.
- Stalls the core until the access completes, then returns sign/zero-extended load data or an error pulse.

---
 rtl/cpe_mem_pkg.sv | 44 ++++
 rtl/dmem_ram.sv | 26 ++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpe_mem_pkg.sv
// Shared definitions for the CPE data-memory path: funct3 width codes,
// responder FSM states and the byte-lane helpers used for stores and loads.
package cpe_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Byte-write enables for a store of the given width at byte offset off.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3)
            F3_B:    m = 4'b0001 << off;
            F3_H:    m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {off, 3'b000};
        case (f3)
            F3_B:    r = {{24{s[7]}}, s[7:0]};
            F3_H:    r = {{16{s[15]}}, s[15:0]};
            F3_BU:   r = {24'd0, s[7:0]};
            F3_HU:   r = {16'd0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are not reset.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write and registered (read-first) read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (we[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures a load/store from the core, stalls it for
// WAIT_STATES+1 cycles, services it against dmem_ram and returns extended
// load data or an error pulse. Define DMEM_MMIO_EN to add the mmio_w_o
// output register at MMIO_ADDR.
module dmem_responder
    import cpe_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic        clk_w_i,
    input  logic        rst_w_i_h,
    input  logic        mem_rd_w_i_h,
    input  logic        mem_wr_w_i_h,
    input  logic [31:0] addr_w_i,
    input  logic [31:0] wdata_w_i,
    input  logic [2:0]  funct3_w_i,
    output logic        stall_w_o_h,
    output logic [31:0] rdata_w_o,
    output logic        rdata_valid_w_o_h,
    output logic        err_w_o_h
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_w_o
`endif
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;
    logic        rd_q, wr_q, err_q;

    logic        req, dec_err, misaligned, mmio_hit;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_f3;
    logic        cur_rd, cur_wr, cur_err, cur_mmio, go_resp;
    logic [31:0] ram_q;

    assign req = mem_rd_w_i_h | mem_wr_w_i_h;

    // With zero wait states the access is serviced on the capture edge, so
    // the RAM and error logic look at the live inputs while IDLE and at the
    // captured copy otherwise.
    assign cur_addr  = (state == S_IDLE) ? addr_w_i     : addr_q;
    assign cur_wdata = (state == S_IDLE) ? wdata_w_i    : wdata_q;
    assign cur_f3    = (state == S_IDLE) ? funct3_w_i   : f3_q;
    assign cur_rd    = (state == S_IDLE) ? mem_rd_w_i_h : rd_q;
    assign cur_wr    = (state == S_IDLE) ? mem_wr_w_i_h : wr_q;
    assign cur_err   = (state == S_IDLE) ? dec_err      : err_q;

`ifdef DMEM_MMIO_EN
    assign cur_mmio = (cur_addr == MMIO_ADDR);
    assign mmio_hit = (addr_w_i == MMIO_ADDR);
`else
    assign cur_mmio = 1'b0;
    assign mmio_hit = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cur_addr[31:AW+2], MMIO_ADDR};
`endif

    // Decode alignment, illegal width codes, rd+wr conflict and sub-word MMIO.
    always_comb begin
        misaligned = 1'b0;
        case (funct3_w_i)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = addr_w_i[0];
            F3_W:        misaligned = (addr_w_i[1:0] != 2'b00);
            default:     misaligned = 1'b1;
        endcase
        dec_err = (mem_rd_w_i_h & mem_wr_w_i_h) | misaligned
                | (mem_wr_w_i_h & funct3_w_i[2])
                | (mmio_hit & (funct3_w_i != F3_W));
    end

    assign go_resp = ((state == S_IDLE) && req && (WAIT_STATES == 0))
                   || ((state == S_WAIT) && (cnt == 4'd0));

    assign stall_w_o_h = ~rst_w_i_h & (((state == S_IDLE) & req) | (state == S_WAIT));

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk_w_i),
        .en    (go_resp & ~cur_err & ~cur_mmio & ~rst_w_i_h),
        .we    (cur_wr ? lane_mask(cur_f3, cur_addr[1:0]) : 4'b0000),
        .idx   (cur_addr[AW+1:2]),
        .wdata (cur_wdata << {cur_addr[1:0], 3'b000}),
        .rdata (ram_q)
    );

`ifdef DMEM_MMIO_EN
    // Output register written by a clean SW to MMIO_ADDR on the edge entering RESP.
    always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
        if (rst_w_i_h)                                mmio_w_o <= '0;
        else if (go_resp & cur_wr & ~cur_err & cur_mmio) mmio_w_o <= cur_wdata;
    end
    assign rdata_w_o = !rdata_valid_w_o_h ? '0
                     : (cur_mmio ? mmio_w_o : load_extend(ram_q, addr_q[1:0], f3_q));
`else
    assign rdata_w_o = rdata_valid_w_o_h ? load_extend(ram_q, addr_q[1:0], f3_q) : '0;
`endif

    // Request FSM: capture in IDLE, count wait states, pulse the response.
    always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
        if (rst_w_i_h) begin
            state             <= S_IDLE;
            cnt               <= '0;
            addr_q            <= '0;
            wdata_q           <= '0;
            f3_q              <= '0;
            rd_q              <= 1'b0;
            wr_q              <= 1'b0;
            err_q             <= 1'b0;
            rdata_valid_w_o_h <= 1'b0;
            err_w_o_h         <= 1'b0;
        end else begin
            rdata_valid_w_o_h <= go_resp & cur_rd & ~cur_err;
            err_w_o_h         <= go_resp & cur_err;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr_w_i;
                        wdata_q <= wdata_w_i;
                        f3_q    <= funct3_w_i;
                        rd_q    <= mem_rd_w_i_h;
                        wr_q    <= mem_wr_w_i_h;
                        err_q   <= dec_err;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WS_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
